// File: rtl/ad_ip_jesd204_tpl_pkg.sv
// Shared definitions for the JESD204 ADC transport layer: sync FSM encoding,
// padding mode constants and the frame geometry helpers.
package ad_ip_jesd204_tpl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2
   } sync_state_t;

   localparam int PAD_MSB = 0;
   localparam int PAD_LSB = 1;

   // Octets per lane per frame.
   function automatic int calc_f(input int lanes, input int chans, input int spf, input int np);
      return (chans * spf * np) / (8 * lanes);
   endfunction

   // Samples per converter per link beat.
   function automatic int calc_dpw(input int lanes, input int chans, input int np, input int opb);
      return (opb * 8 * lanes) / (chans * np);
   endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_deframer_if.sv
// Beat-level bus between the RX link layer, the deframer and the ADC/DMA side.
interface ad_ip_jesd204_tpl_adc_deframer_if #(
   parameter int LINK_W = 128,
   parameter int ADC_W  = 128
);
   logic              link_valid;
   logic [LINK_W-1:0] link_data;
   logic              adc_valid;
   logic [ADC_W-1:0]  adc_data;

   modport master (
      output link_valid, link_data,
      input  adc_valid, adc_data
   );

   modport slave (
      input  link_valid, link_data,
      output adc_valid, adc_data
   );
endinterface

// File: rtl/ad_ip_jesd204_tpl_adc_pad.sv
// Pads one NP-bit converter sample to the DMA sample width and registers it.
module ad_ip_jesd204_tpl_adc_pad
   import ad_ip_jesd204_tpl_pkg::*;
#(
   parameter int BITS_PER_SAMPLE      = 16,
   parameter int DMA_BITS_PER_SAMPLE  = 16,
   parameter int PADDING_TO_MSB_LSB_N = 0,
   parameter int SIGN_EXTEND          = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           en,
   input  logic [BITS_PER_SAMPLE-1:0]     sample,
   output logic [DMA_BITS_PER_SAMPLE-1:0] padded
);

   // Equal widths fall out naturally: zero shift, and a same-width cast.
   function automatic logic [DMA_BITS_PER_SAMPLE-1:0] pad_sample(input logic [BITS_PER_SAMPLE-1:0] s);
      logic signed [BITS_PER_SAMPLE-1:0] ss;
      ss = s;
      if (PADDING_TO_MSB_LSB_N == PAD_MSB)
         return DMA_BITS_PER_SAMPLE'(s) << (DMA_BITS_PER_SAMPLE - BITS_PER_SAMPLE);
      else if (SIGN_EXTEND != 0)
         return DMA_BITS_PER_SAMPLE'(ss);
      else
         return DMA_BITS_PER_SAMPLE'(s);
   endfunction

   // stage 2: padded sample register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         padded <= '0;
      else if (en)
         padded <= pad_sample(sample);
   end

endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_deframer.sv
// JESD204 RX transport layer: deframes lane beats into per-converter samples,
// pads them for DMA, gates validity with the ext-sync FSM and tracks overflow.
// Optional AD_IP_JESD204_TPL_ADC_BEAT_CNT_EN adds a 32-bit output beat counter.
module ad_ip_jesd204_tpl_adc_deframer
   import ad_ip_jesd204_tpl_pkg::*;
#(
   parameter int NUM_LANES            = 4,
   parameter int NUM_CHANNELS         = 2,
   parameter int SAMPLES_PER_FRAME    = 1,
   parameter int BITS_PER_SAMPLE      = 16,
   parameter int OCTETS_PER_BEAT      = 4,
   parameter int DMA_BITS_PER_SAMPLE  = 16,
   parameter int PADDING_TO_MSB_LSB_N = 0,
   parameter int SIGN_EXTEND          = 1,
   parameter int EXT_SYNC             = 0
) (
   input  logic link_clk,
   input  logic link_resetn,
   ad_ip_jesd204_tpl_adc_deframer_if.slave tpl,
   input  logic adc_dovf,
   input  logic adc_ovf_clr,
   output logic adc_ovf_status,
   input  logic adc_ext_sync_arm,
   input  logic adc_ext_sync_disarm,
   input  logic adc_sync_in,
   output logic adc_sync_status
`ifdef AD_IP_JESD204_TPL_ADC_BEAT_CNT_EN
   ,
   output logic [31:0] adc_beat_cnt
`endif
);

   localparam int F    = calc_f(NUM_LANES, NUM_CHANNELS, SAMPLES_PER_FRAME, BITS_PER_SAMPLE);
   localparam int DPW  = calc_dpw(NUM_LANES, NUM_CHANNELS, BITS_PER_SAMPLE, OCTETS_PER_BEAT);
   localparam int NFR  = OCTETS_PER_BEAT / F;
   localparam int FW   = NUM_LANES * F * 8;
   localparam int OPB8 = OCTETS_PER_BEAT * 8;
   localparam int NSMP = NUM_CHANNELS * DPW;
   localparam int DBPS = DMA_BITS_PER_SAMPLE;
   localparam int NP   = BITS_PER_SAMPLE;
   localparam int S    = SAMPLES_PER_FRAME;

   sync_state_t state, state_nxt;
   logic        run;

   logic [FW-1:0]   frame    [NFR];
   logic [NP-1:0]   deframed [NSMP];
   logic [NP-1:0]   samp_p1  [NSMP];
   logic [DBPS-1:0] padded   [NSMP];
   logic            vld_p1;
   logic            vld_p2;

   always_ff @(posedge link_clk or negedge link_resetn) begin
      if (!link_resetn)
         state <= (EXT_SYNC != 0) ? ST_IDLE : ST_RUN;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (EXT_SYNC == 0) begin
         state_nxt = ST_RUN;
      end else begin
         case (state)
            ST_IDLE:  if (adc_ext_sync_arm) state_nxt = ST_ARMED;
            ST_ARMED: begin
               if (adc_ext_sync_disarm)
                  state_nxt = ST_RUN;
               else if (adc_sync_in)
                  state_nxt = ST_RUN;
            end
            ST_RUN:   if (adc_ext_sync_arm) state_nxt = ST_ARMED;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   assign run             = (state == ST_RUN);
   assign adc_sync_status = (EXT_SYNC != 0) && (state == ST_ARMED);

   // Frame k gathers octet k*F+j of every lane; the earliest octet of each
   // lane lands at the MSB end, lane 0 first, which is the octet reversal.
   always_comb begin
      for (int k = 0; k < NFR; k++) begin
         frame[k] = '0;
         for (int l = 0; l < NUM_LANES; l++)
            for (int j = 0; j < F; j++)
               frame[k][FW-(l*F+j+1)*8 +: 8] = tpl.link_data[l*OPB8 + (k*F+j)*8 +: 8];
      end
   end

   always_comb begin
      for (int i = 0; i < NSMP; i++)
         deframed[i] = '0;
      for (int k = 0; k < NFR; k++)
         for (int c = 0; c < NUM_CHANNELS; c++)
            for (int s = 0; s < S; s++)
               deframed[c*DPW + k*S + s] = frame[k][FW-(c*S+s+1)*NP +: NP];
   end

   // stage 1: deframed samples, gated by the sync FSM
   always_ff @(posedge link_clk or negedge link_resetn) begin
      if (!link_resetn) begin
         vld_p1 <= 1'b0;
         for (int i = 0; i < NSMP; i++)
            samp_p1[i] <= '0;
      end else begin
         vld_p1 <= tpl.link_valid & run;
         if (tpl.link_valid & run)
            samp_p1 <= deframed;
      end
   end

   // stage 2: padded samples
   for (genvar g = 0; g < NSMP; g++) begin : g_pad
      ad_ip_jesd204_tpl_adc_pad #(
         .BITS_PER_SAMPLE      (NP),
         .DMA_BITS_PER_SAMPLE  (DBPS),
         .PADDING_TO_MSB_LSB_N (PADDING_TO_MSB_LSB_N),
         .SIGN_EXTEND          (SIGN_EXTEND)
      ) u_pad (
         .clk    (link_clk),
         .rst_n  (link_resetn),
         .en     (vld_p1),
         .sample (samp_p1[g]),
         .padded (padded[g])
      );
   end

   always_ff @(posedge link_clk or negedge link_resetn) begin
      if (!link_resetn)
         vld_p2 <= 1'b0;
      else
         vld_p2 <= vld_p1;
   end

   always_comb begin
      tpl.adc_data = '0;
      for (int i = 0; i < NSMP; i++)
         tpl.adc_data[i*DBPS +: DBPS] = padded[i];
   end

   assign tpl.adc_valid = vld_p2;

   // A set in the same cycle as a clear must not be lost.
   always_ff @(posedge link_clk or negedge link_resetn) begin
      if (!link_resetn)
         adc_ovf_status <= 1'b0;
      else if (adc_dovf)
         adc_ovf_status <= 1'b1;
      else if (adc_ovf_clr)
         adc_ovf_status <= 1'b0;
   end

`ifdef AD_IP_JESD204_TPL_ADC_BEAT_CNT_EN
   logic [31:0] beat_cnt;

   always_ff @(posedge link_clk or negedge link_resetn) begin
      if (!link_resetn)
         beat_cnt <= '0;
      else if (adc_ovf_clr)
         beat_cnt <= '0;
      else if (vld_p2)
         beat_cnt <= beat_cnt + 32'd1;
   end

   assign adc_beat_cnt = beat_cnt;
`endif

endmodule
